// File: rtl/spi_msg_pkg.sv
// spi_msg_pkg: shared frame tags, system-state codes and the receiver FSM
// state type. Define SPI_MSG_RX_CHECKSUM_EN to add the CHECK state and a
// trailing checksum byte.
package spi_msg_pkg;

  // Frame tag byte values
  localparam logic [7:0] TAG_STATE  = 8'h01;
  localparam logic [7:0] TAG_RESULT = 8'h02;

  // System-state codes
  localparam logic [7:0] READY  = 8'd1;
  localparam logic [7:0] LISTEN = 8'd2;
  localparam logic [7:0] DONE   = 8'd10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TAG     = 3'd1,
    PAYLOAD = 3'd2,
    DRAIN   = 3'd3
`ifdef SPI_MSG_RX_CHECKSUM_EN
    , CHECK = 3'd4
`endif
  } fsm_state_e;

  function automatic logic legal_tag(input logic [7:0] b);
    return (b == TAG_STATE) || (b == TAG_RESULT);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser for one asynchronous input plus
// rise/fall detection on the synchronised copy. Edges stay masked until the
// chain holds real samples, so leaving reset never produces a false edge.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;
  logic [STAGES:0]   prime;

  // Shift the input through the chain, remember the last output, and count
  // off the cycles needed before the edge detector may trust its history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
      prime <= '0;
    end else begin
      // NOTE: non-blocking so each stage takes its predecessor's old value;
      // blocking assignments would collapse the chain into a single flop.
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
      prime <= {prime[STAGES-1:0], 1'b1};
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = prime[STAGES] &  q & ~prev;
  assign fall = prime[STAGES] & ~q &  prev;

endmodule

// File: rtl/spi_msg_rx.sv
// spi_msg_rx: SPI mode-0 slave that receives tagged two-byte frames
// (tag, payload) and publishes system-state or classification results,
// returning tx_byte to the master in every byte slot.
// Optional feature macro: SPI_MSG_RX_CHECKSUM_EN (third byte = tag ^ payload).
module spi_msg_rx
  import spi_msg_pkg::*;
#(
  parameter int N_STATES    = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sck,
  input  logic       sdi,
  input  logic       ss,
  output logic       sdo,
  input  logic [7:0] tx_byte,
  output logic [7:0] sys_state,
  output logic [7:0] result,
  output logic       state_valid,
  output logic       result_valid,
  output logic       frame_err
);

  localparam logic [7:0] MAX_STATE = 8'(N_STATES);

  logic sck_q, sck_rise, sck_fall;
  logic sdi_q, sdi_rise, sdi_fall;
  logic ss_q, ss_rise, ss_fall;
  logic unused_sdi_edges;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
    .clk(clk), .reset(reset), .d(sck), .q(sck_q), .rise(sck_rise), .fall(sck_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sdi_sync (
    .clk(clk), .reset(reset), .d(sdi), .q(sdi_q), .rise(sdi_rise), .fall(sdi_fall));
  // ss idles high, so its synchroniser resets to 1
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
    .clk(clk), .reset(reset), .d(ss), .q(ss_q), .rise(ss_rise), .fall(ss_fall));

  assign unused_sdi_edges = sdi_rise ^ sdi_fall ^ sck_q;

  logic [6:0] rx_shift;
  logic [2:0] bit_cnt;
  logic [7:0] rx_byte;
  logic       byte_done;
  logic [7:0] tx_shift;

  assign rx_byte   = {rx_shift, sdi_q};
  assign byte_done = ~ss_q & sck_rise & (bit_cnt == 3'd7);

  // Receive shifter and bit counter: sample on sck rise, clear while deselected.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_shift <= '0;
      bit_cnt  <= '0;
    end else if (ss_q) begin
      rx_shift <= '0;
      bit_cnt  <= '0;
    end else if (sck_rise) begin
      rx_shift <= rx_byte[6:0];
      bit_cnt  <= bit_cnt + 3'd1;
    end
  end

  // Transmit shifter: load tx_byte at ss fall and each byte boundary; shift on
  // sck fall except the fall right after a boundary, which must keep the new MSB.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_shift <= '0;
    end else if (ss_fall || byte_done) begin
      tx_shift <= tx_byte;
    end else if (sck_fall && !ss_q && (bit_cnt != 3'd0)) begin
      tx_shift <= {tx_shift[6:0], 1'b0};
    end
  end

  assign sdo = ~ss_q & tx_shift[7];

  fsm_state_e state;
  logic [7:0] tag_q;
  logic       commit;
  logic       cs_ok;
  logic [7:0] pay;
  logic       mid_frame;

`ifdef SPI_MSG_RX_CHECKSUM_EN
  logic [7:0] payload_q;
  assign commit    = (state == CHECK) && byte_done;
  assign cs_ok     = (rx_byte == (tag_q ^ payload_q));
  assign pay       = payload_q;
  assign mid_frame = (state == TAG) || (state == PAYLOAD) || (state == CHECK);
`else
  assign commit    = (state == PAYLOAD) && byte_done;
  assign cs_ok     = 1'b1;
  assign pay       = rx_byte;
  assign mid_frame = (state == TAG) || (state == PAYLOAD);
`endif

  // Frame FSM with registered outputs; ss rise aborts from any state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      tag_q        <= '0;
`ifdef SPI_MSG_RX_CHECKSUM_EN
      payload_q    <= '0;
`endif
      sys_state    <= '0;
      result       <= '0;
      state_valid  <= 1'b0;
      result_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state_valid  <= 1'b0;
      result_valid <= 1'b0;
      if (ss_rise) begin
        if (mid_frame) frame_err <= 1'b1;
        state <= IDLE;
      end else begin
        case (state)
          IDLE:    if (ss_fall) state <= TAG;
          TAG: begin
            if (byte_done) begin
              tag_q <= rx_byte;
              if (legal_tag(rx_byte)) begin
                state <= PAYLOAD;
              end else begin
                frame_err <= 1'b1;
                state     <= DRAIN;
              end
            end
          end
          PAYLOAD: begin
            if (byte_done) begin
`ifdef SPI_MSG_RX_CHECKSUM_EN
              payload_q <= rx_byte;
              state     <= CHECK;
`else
              state     <= IDLE;
`endif
            end
          end
`ifdef SPI_MSG_RX_CHECKSUM_EN
          CHECK:   if (byte_done) state <= IDLE;
`endif
          DRAIN:   state <= DRAIN;
          default: state <= IDLE;
        endcase

        if (commit) begin
          if (!cs_ok) begin
            frame_err <= 1'b1;
          end else if (tag_q == TAG_STATE) begin
            if (pay > MAX_STATE) begin
              frame_err <= 1'b1;
            end else begin
              sys_state   <= pay;
              state_valid <= 1'b1;
            end
          end else begin
            result       <= pay;
            result_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule
